alu_seq_exec: RTL and testbench

ALU_SEQ_EXEC -- requirements
Module: alu_seq_exec

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/alu_iter_unit.sv | 104 ++++++++++
 rtl/alu_seq_exec.sv | 146 ++++++++++++++
 tb/tb_alu_seq_exec.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : ALU control codes and sequencer state encoding, shared by the
//               sequential executor and the ALU-control decoder.
//               Optional feature macro: ALU_SEQ_MUL_EN (adds the MUL state).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    // 4-bit operation codes emitted by the ALU-control decoder
    localparam logic [3:0] C_ALU_AND  = 4'b0000;
    localparam logic [3:0] C_ALU_OR   = 4'b0001;
    localparam logic [3:0] C_ALU_ADD  = 4'b0010;
    localparam logic [3:0] C_ALU_SLTU = 4'b0011;
    localparam logic [3:0] C_ALU_XOR  = 4'b0100;
    localparam logic [3:0] C_ALU_SLL  = 4'b0101;
    localparam logic [3:0] C_ALU_SUB  = 4'b0110;
    localparam logic [3:0] C_ALU_SRL  = 4'b0111;
    localparam logic [3:0] C_ALU_MUL  = 4'b1000;
    localparam logic [3:0] C_ALU_SRA  = 4'b1101;

    // Sequencer states; MUL exists only when the multiplier is built
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
`ifdef ALU_SEQ_MUL_EN
        ,
        ST_MUL   = 2'd2
`endif
    } alu_state_e;

    // True for the three iterative shift codes
    function automatic logic is_shift(input logic [3:0] ctrl);
        return (ctrl == C_ALU_SLL) || (ctrl == C_ALU_SRL) || (ctrl == C_ALU_SRA);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_iter_unit.sv
// ============================================================================
// Module      : alu_iter_unit
// Description : Multi-cycle datapath: one-bit-per-cycle shifter and, when
//               ALU_SEQ_MUL_EN is defined, an unsigned shift-add multiplier.
//               'done' is high during the final iteration cycle and 'result'
//               then carries the completed value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN + 1);

    logic [3:0]      r_op;
    logic [XLEN-1:0] r_val;     // shift operand, or multiplicand for MUL
    logic [CNT_W-1:0] r_cnt;    // iterations still to perform
    logic [XLEN-1:0] w_shift_next;

`ifdef ALU_SEQ_MUL_EN
    logic [XLEN-1:0] r_mplier;
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] w_mul_next;
    logic            w_is_mul;

    assign w_is_mul   = (op == C_ALU_MUL);
    assign w_mul_next = r_acc + (r_mplier[0] ? r_val : '0);
`else
    // Only the shift amount of op_b matters without the multiplier
    logic w_unused_opb;
    assign w_unused_opb = ^op_b[XLEN-1:5];
`endif

    // One-bit shift of the working value according to the latched op
    always_comb begin
        w_shift_next = r_val;
        case (r_op)
            C_ALU_SLL: w_shift_next = {r_val[XLEN-2:0], 1'b0};
            C_ALU_SRL: w_shift_next = {1'b0, r_val[XLEN-1:1]};
            C_ALU_SRA: w_shift_next = {r_val[XLEN-1], r_val[XLEN-1:1]};
            default:   w_shift_next = r_val;
        endcase
    end

    assign done = (r_cnt == CNT_W'(1));

`ifdef ALU_SEQ_MUL_EN
    assign result = (r_op == C_ALU_MUL) ? w_mul_next : w_shift_next;
`else
    assign result = w_shift_next;
`endif

    // Latch operands on start, then iterate until the counter empties
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op  <= C_ALU_ADD;
            r_val <= '0;
            r_cnt <= '0;
`ifdef ALU_SEQ_MUL_EN
            r_mplier <= '0;
            r_acc    <= '0;
`endif
        end else if (start) begin
            r_op  <= op;
            r_val <= op_a;
`ifdef ALU_SEQ_MUL_EN
            r_mplier <= op_b;
            r_acc    <= '0;
            r_cnt    <= w_is_mul ? CNT_W'(XLEN) : CNT_W'(op_b[4:0]);
`else
            r_cnt    <= CNT_W'(op_b[4:0]);
`endif
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
`ifdef ALU_SEQ_MUL_EN
            if (r_op == C_ALU_MUL) begin
                r_acc    <= w_mul_next;
                r_val    <= {r_val[XLEN-2:0], 1'b0};
                r_mplier <= {1'b0, r_mplier[XLEN-1:1]};
            end else begin
                r_val <= w_shift_next;
            end
`else
            r_val <= w_shift_next;
`endif
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_seq_exec.sv
// ============================================================================
// Module      : alu_seq_exec
// Description : Sequential ALU executor with valid/ready handshake on both
//               sides. Logic ops, ADD/SUB and SLTU finish in one cycle;
//               shifts iterate one bit per cycle. Define ALU_SEQ_MUL_EN to
//               add a fixed-latency shift-add multiplier on code 1000.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq_exec
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    alu_state_e      r_state;
    alu_state_e      w_state_nxt;
    logic [XLEN-1:0] r_result;
    logic            r_out_valid;
    logic [XLEN-1:0] w_alu_res;
    logic            w_accept;
    logic            w_go_shift;
    logic            w_go_mul;
    logic            w_go_iter;
    logic            w_iter_done;
    logic [XLEN-1:0] w_iter_res;

    // A zero shift amount is handled as a single-cycle pass-through
    assign w_go_shift = is_shift(alu_ctrl) && (op_b[4:0] != 5'd0);
`ifdef ALU_SEQ_MUL_EN
    assign w_go_mul   = (alu_ctrl == C_ALU_MUL);
`else
    assign w_go_mul   = 1'b0;
`endif
    assign w_go_iter  = w_go_shift || w_go_mul;

    // Accept only when idle and the result register is free or draining
    assign in_ready  = rst_n && (r_state == ST_IDLE) && (!r_out_valid || out_ready);
    assign w_accept  = in_valid && in_ready;
    assign busy      = (r_state != ST_IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = (r_result == '0);

    // Single-cycle operation results; unknown codes fall back to ADD
    always_comb begin
        w_alu_res = op_a + op_b;
        case (alu_ctrl)
            C_ALU_AND:  w_alu_res = op_a & op_b;
            C_ALU_OR:   w_alu_res = op_a | op_b;
            C_ALU_ADD:  w_alu_res = op_a + op_b;
            C_ALU_SUB:  w_alu_res = op_a - op_b;
            C_ALU_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            C_ALU_XOR:  w_alu_res = op_a ^ op_b;
            C_ALU_SLL,
            C_ALU_SRL,
            C_ALU_SRA:  w_alu_res = op_a;
            default:    w_alu_res = op_a + op_b;
        endcase
    end

    alu_iter_unit #(
        .XLEN   (XLEN)
    ) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (w_accept && w_go_iter),
        .op     (alu_ctrl),
        .op_a   (op_a),
        .op_b   (op_b),
        .done   (w_iter_done),
        .result (w_iter_res)
    );

    // Next-state logic: leave IDLE for iterative ops, return when done
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_go_shift) begin
                    w_state_nxt = ST_SHIFT;
                end
`ifdef ALU_SEQ_MUL_EN
                if (w_accept && w_go_mul) begin
                    w_state_nxt = ST_MUL;
                end
`endif
            end
            ST_SHIFT: begin
                if (w_iter_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            ST_MUL: begin
                if (w_iter_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Result register: load on completion, hold until the consumer drains it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result    <= '0;
            r_out_valid <= 1'b0;
        end else if (w_accept && !w_go_iter) begin
            r_result    <= w_alu_res;
            r_out_valid <= 1'b1;
        end else if (busy && w_iter_done) begin
            r_result    <= w_iter_res;
            r_out_valid <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_exec.sv
// ============================================================================
// Module      : tb_alu_seq_exec
// Description : Self-checking bench for alu_seq_exec (XLEN = 32). Honours
//               ALU_SEQ_MUL_EN for the expected behaviour of code 1000.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_seq_exec;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b1;
    logic [3:0]  alu_ctrl  = 4'b0000;
    logic [31:0] op_a      = 32'd0;
    logic [31:0] op_b      = 32'd0;
    logic        in_ready;
    logic        out_valid;
    logic        zero;
    logic        busy;
    logic [31:0] result;

    int n_cmp = 0;
    int n_bad = 0;

    alu_seq_exec #(
        .XLEN      (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result of one operation, straight from the operation table
    function automatic logic [31:0] ref_res(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0011: return (a < b) ? 32'd1 : 32'd0;
            4'b0100: return a ^ b;
            4'b0101: return a << sh;
            4'b0111: return a >> sh;
            4'b1101: return $unsigned($signed(a) >>> sh);
`ifdef ALU_SEQ_MUL_EN
            4'b1000: return a * b;
`endif
            default: return a + b;
        endcase
    endfunction

    // Reference latency in cycles from accept to out_valid
    function automatic int ref_lat(input logic [3:0] c, input logic [31:0] b);
        if (c == 4'b0101 || c == 4'b0111 || c == 4'b1101) return 1 + int'(b[4:0]);
`ifdef ALU_SEQ_MUL_EN
        if (c == 4'b1000) return 33;
`endif
        return 1;
    endfunction

    // Transaction-level model: cycles left until completion, plus output register
    int          m_left = 0;
    logic        m_ov   = 1'b0;
    logic [31:0] m_res  = 32'd0;
    logic [31:0] m_pend = 32'd0;
    logic        m_in_ready;

    assign m_in_ready = rst_n && (m_left == 0) && (!m_ov || out_ready);

    // Model update on each clock edge, cleared by reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_ov   <= 1'b0;
            m_res  <= 32'd0;
            m_pend <= 32'd0;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_ov  <= 1'b1;
                m_res <= m_pend;
            end
        end else begin
            if (m_ov && out_ready) m_ov <= 1'b0;
            if (in_valid && m_in_ready) begin
                if (ref_lat(alu_ctrl, op_b) == 1) begin
                    m_ov  <= 1'b1;
                    m_res <= ref_res(alu_ctrl, op_a, op_b);
                end else begin
                    m_left <= ref_lat(alu_ctrl, op_b) - 1;
                    m_pend <= ref_res(alu_ctrl, op_a, op_b);
                end
            end
        end
    end

    // Every cycle: DUT outputs against the model
    always @(negedge clk) begin
        check("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
        check("result", result, m_res);
        check("zero", {31'd0, zero}, {31'd0, (m_res == 32'd0)});
        check("busy", {31'd0, busy}, {31'd0, (m_left != 0)});
        check("in_ready", {31'd0, in_ready}, {31'd0, m_in_ready});
    end

    // Offer one operation until accepted, then scramble the inputs
    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        bit ok = 1'b0;
        alu_ctrl = c;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk);
            if (m_in_ready) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_timeout: got no accept expected accept at %0t", $time);
        end
        #1;
        in_valid = 1'b0;
        op_a     = $urandom;
        op_b     = $urandom;
        alu_ctrl = 4'($urandom);
    endtask

    // Count negedges until out_valid rises (0 if it never does)
    task automatic wait_ov(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (out_valid) begin
                cyc = i;
                break;
            end
        end
    endtask

    localparam int NT = 14;
    logic [3:0]  tv_c   [NT];
    logic [31:0] tv_a   [NT];
    logic [31:0] tv_b   [NT];
    logic [31:0] tv_exp [NT];
    int          tv_lat [NT];

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish at %0t", $time);
        $fatal(1);
    end

    // Directed scenario sequence
    initial begin
        int k;
        tv_c[0]  = 4'b0001; tv_a[0]  = 32'hF0F0_0000; tv_b[0]  = 32'h0F0F_1234; tv_exp[0]  = 32'hFFFF_1234; tv_lat[0]  = 1;
        tv_c[1]  = 4'b0100; tv_a[1]  = 32'hAAAA_5555; tv_b[1]  = 32'hFFFF_0000; tv_exp[1]  = 32'h5555_5555; tv_lat[1]  = 1;
        tv_c[2]  = 4'b0011; tv_a[2]  = 32'h0000_0001; tv_b[2]  = 32'hFFFF_FFFF; tv_exp[2]  = 32'h0000_0001; tv_lat[2]  = 1;
        tv_c[3]  = 4'b0011; tv_a[3]  = 32'hFFFF_FFFF; tv_b[3]  = 32'h0000_0001; tv_exp[3]  = 32'h0000_0000; tv_lat[3]  = 1;
        tv_c[4]  = 4'b0011; tv_a[4]  = 32'h0000_0005; tv_b[4]  = 32'h0000_0005; tv_exp[4]  = 32'h0000_0000; tv_lat[4]  = 1;
        tv_c[5]  = 4'b0111; tv_a[5]  = 32'h8000_0000; tv_b[5]  = 32'h0000_0023; tv_exp[5]  = 32'h1000_0000; tv_lat[5]  = 4;
        tv_c[6]  = 4'b0101; tv_a[6]  = 32'h1234_5678; tv_b[6]  = 32'hFFFF_FFE0; tv_exp[6]  = 32'h1234_5678; tv_lat[6]  = 1;
        tv_c[7]  = 4'b1101; tv_a[7]  = 32'h7000_0000; tv_b[7]  = 32'h0000_0004; tv_exp[7]  = 32'h0700_0000; tv_lat[7]  = 5;
        tv_c[8]  = 4'b1101; tv_a[8]  = 32'hF000_0000; tv_b[8]  = 32'h0000_0004; tv_exp[8]  = 32'hFF00_0000; tv_lat[8]  = 5;
        tv_c[9]  = 4'b1111; tv_a[9]  = 32'h0000_0003; tv_b[9]  = 32'h0000_0004; tv_exp[9]  = 32'h0000_0007; tv_lat[9]  = 1;
`ifdef ALU_SEQ_MUL_EN
        tv_c[10] = 4'b1000; tv_a[10] = 32'h0001_0000; tv_b[10] = 32'h0001_0001; tv_exp[10] = 32'h0001_0000; tv_lat[10] = 33;
`else
        tv_c[10] = 4'b1000; tv_a[10] = 32'h0001_0000; tv_b[10] = 32'h0001_0001; tv_exp[10] = 32'h0002_0001; tv_lat[10] = 1;
`endif
        tv_c[11] = 4'b0110; tv_a[11] = 32'h0000_0000; tv_b[11] = 32'h0000_0001; tv_exp[11] = 32'hFFFF_FFFF; tv_lat[11] = 1;
        tv_c[12] = 4'b0010; tv_a[12] = 32'h7FFF_FFFF; tv_b[12] = 32'h0000_0001; tv_exp[12] = 32'h8000_0000; tv_lat[12] = 1;
        tv_c[13] = 4'b0101; tv_a[13] = 32'h0000_0001; tv_b[13] = 32'h0000_001F; tv_exp[13] = 32'h8000_0000; tv_lat[13] = 32;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // ADD wrap, accepted on the first edge after reset release
        issue(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001);
        @(negedge clk);
        check("add_wrap_valid", {31'd0, out_valid}, 32'd1);
        check("add_wrap_result", result, 32'h0000_0000);
        check("add_wrap_zero", {31'd0, zero}, 32'd1);

        // SRA by 31 with junk offered while busy
        issue(4'b1101, 32'h8000_0000, 32'h0000_001F);
        in_valid = 1'b1;
        alu_ctrl = 4'b0010;
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 10) in_valid = 1'b0;
            if (out_valid) begin
                k = i;
                break;
            end
            check("sra_busy", {31'd0, busy}, 32'd1);
            check("sra_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        check("sra_latency", k, 32);
        check("sra_result", result, 32'hFFFF_FFFF);

        // SUB held under back-pressure, then drain and accept together
        @(posedge clk);
        #1 out_ready = 1'b0;
        issue(4'b0110, 32'd5, 32'd7);
        repeat (4) begin
            @(negedge clk);
            check("sub_hold_valid", {31'd0, out_valid}, 32'd1);
            check("sub_hold_result", result, 32'hFFFF_FFFE);
            check("sub_hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        issue(4'b0000, 32'h0000_00F0, 32'h0000_000F);
        @(negedge clk);
        check("and_nobubble_valid", {31'd0, out_valid}, 32'd1);
        check("and_nobubble_result", result, 32'h0000_0000);
        check("and_nobubble_zero", {31'd0, zero}, 32'd1);

        // Non-zero result, then SLL interrupted by reset
        issue(4'b0010, 32'd1, 32'd1);
        wait_ov(k);
        check("add_small_result", result, 32'd2);
        issue(4'b0101, 32'h0000_0001, 32'h0000_0004);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("sll_rst_valid", {31'd0, out_valid}, 32'd0);
        check("sll_rst_result", result, 32'd0);
        check("sll_rst_zero", {31'd0, zero}, 32'd1);
        check("sll_rst_busy", {31'd0, busy}, 32'd0);
        check("sll_rst_in_ready", {31'd0, in_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check("sll_discarded", {31'd0, out_valid}, 32'd0);
        end

        // Directed vector table
        for (int t = 0; t < NT; t++) begin
            issue(tv_c[t], tv_a[t], tv_b[t]);
            wait_ov(k);
            check($sformatf("vec%0d_latency", t), k, tv_lat[t]);
            check($sformatf("vec%0d_result", t), result, tv_exp[t]);
            check($sformatf("vec%0d_zero", t), {31'd0, zero}, {31'd0, (tv_exp[t] == 32'd0)});
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
